// File: rtl/keypad_lockout_ctrl.sv
// ---------------------------------------------------------------------------
// keypad_lockout_ctrl
//
// Sits between the keypad decoder and the password FSM.
// - Counts consecutive failed password attempts. It detects the FAIL word
//   appearing on the FSM's display output.
// - After MAX_FAILS consecutive failures it locks the keypad for LOCK_SEC
//   seconds.
// - Owns the 4-digit display. While armed it shows the FSM word. While
//   locked it shows "L-nn", where nn is a BCD countdown of the seconds left.
//
// Parameters
//   MAX_FAILS       consecutive FAILs that trigger lockout (1..15)
//   LOCK_SEC        lockout duration in seconds (1..99)
//   CYCLES_PER_SEC  clk cycles per second
//
// Ports
//   clk            in   1   system clock
//   reset          in   1   asynchronous, active-high reset
//   key_value      in   4   keypad code (0-9 digits, C clear, E enter)
//   key_valid      in   1   one-cycle strobe qualifying key_value
//   fsm_display    in   16  display word from the password FSM
//   fsm_key_value  out  4   key code forwarded to the FSM (combinational)
//   fsm_key_valid  out  1   key strobe, gated off while locked (combinational)
//   display_data   out  16  four nibble character codes for the 7-seg driver
//   locked         out  1   high while the keypad is locked out (registered)
//   fail_count     out  4   current consecutive-fail count (registered)
// ---------------------------------------------------------------------------
module keypad_lockout_ctrl #(
    parameter int unsigned MAX_FAILS      = 3,
    parameter int unsigned LOCK_SEC       = 30,
    parameter int unsigned CYCLES_PER_SEC = 50_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  key_value,
    input  logic        key_valid,
    input  logic [15:0] fsm_display,
    output logic [3:0]  fsm_key_value,
    output logic        fsm_key_valid,
    output logic [15:0] display_data,
    output logic        locked,
    output logic [3:0]  fail_count
);

    localparam int unsigned TIMER_W = (CYCLES_PER_SEC > 1) ? $clog2(CYCLES_PER_SEC) : 1;

    localparam logic [15:0] FAIL_WORD = 16'hDA1E;
    localparam logic [15:0] PASS_WORD = 16'hBACC;
    localparam logic [15:0] IDLE_WORD = 16'hFFFF;
    localparam logic [3:0]  CHAR_L    = 4'hE;
    localparam logic [3:0]  CHAR_DASH = 4'hF;

    // The lockout length is preloaded as two BCD digits.
    localparam logic [3:0]  LOCK_TENS  = 4'(LOCK_SEC / 10);
    localparam logic [3:0]  LOCK_ONES  = 4'(LOCK_SEC % 10);
    localparam logic [3:0]  FAIL_LIMIT = 4'(MAX_FAILS - 1);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(CYCLES_PER_SEC - 1);

    typedef enum logic {
        ST_ARMED  = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t              state_r;
    state_t              state_s;
    logic [3:0]          fail_count_r;
    logic [3:0]          fail_count_s;
    logic [7:0]          countdown_r;
    logic [7:0]          countdown_s;
    logic [TIMER_W-1:0]  sec_timer_r;
    logic [TIMER_W-1:0]  sec_timer_s;
    logic [15:0]         display_r;
    logic [15:0]         display_s;
    logic                locked_r;
    logic [15:0]         prev_disp_r;
    logic                fail_seen_s;
    logic                pass_seen_s;
    logic                tick_s;

    // Decrement a 2-digit BCD value.
    // When the ones digit is 0 it becomes 9 and one is borrowed from the tens digit.
    function automatic logic [7:0] bcd_dec(input logic [7:0] value);
        logic [7:0] result;
        if (value[3:0] == 4'd0) begin
            result = {value[7:4] - 4'd1, 4'd9};
        end else begin
            result = {value[7:4], value[3:0] - 4'd1};
        end
        return result;
    endfunction

    // Detect only the first cycle of FAIL and PASS words.
    // A word that stays on the display is therefore counted once.
    assign fail_seen_s = (fsm_display == FAIL_WORD) && (prev_disp_r != FAIL_WORD);
    assign pass_seen_s = (fsm_display == PASS_WORD) && (prev_disp_r != PASS_WORD);
    assign tick_s      = (sec_timer_r == TIMER_LAST);

    // Keys reach the FSM only while armed; keys pressed while locked are dropped.
    assign fsm_key_value = key_value;
    assign fsm_key_valid = key_valid && (state_r == ST_ARMED);

    assign display_data = display_r;
    assign locked       = locked_r;
    assign fail_count   = fail_count_r;

    // Next-state, fail-count, countdown and display computation.
    always_comb begin
        state_s      = state_r;
        fail_count_s = fail_count_r;
        countdown_s  = countdown_r;
        sec_timer_s  = sec_timer_r;
        display_s    = display_r;
        case (state_r)
            ST_ARMED: begin
                display_s   = fsm_display;
                sec_timer_s = '0;
                if (pass_seen_s) begin
                    fail_count_s = 4'd0;
                end else if (fail_seen_s) begin
                    // Compare with >= so that fail_count can never pass the limit.
                    if (fail_count_r >= FAIL_LIMIT) begin
                        state_s      = ST_LOCKED;
                        fail_count_s = 4'd0;
                        countdown_s  = {LOCK_TENS, LOCK_ONES};
                    end else begin
                        fail_count_s = fail_count_r + 4'd1;
                    end
                end else begin
                    fail_count_s = fail_count_r;
                end
            end
            ST_LOCKED: begin
                display_s = {CHAR_L, CHAR_DASH, countdown_r};
                if (tick_s) begin
                    sec_timer_s = '0;
                    if (countdown_r == 8'h01) begin
                        state_s     = ST_ARMED;
                        countdown_s = 8'h00;
                    end else begin
                        countdown_s = bcd_dec(countdown_r);
                    end
                end else begin
                    sec_timer_s = sec_timer_r + TIMER_W'(1);
                end
            end
            default: begin
                state_s      = ST_ARMED;
                fail_count_s = 4'd0;
                countdown_s  = 8'h00;
                sec_timer_s  = '0;
                display_s    = IDLE_WORD;
            end
        endcase
    end

    // State and datapath registers, with the asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= ST_ARMED;
            fail_count_r <= 4'd0;
            countdown_r  <= 8'h00;
            sec_timer_r  <= '0;
            display_r    <= IDLE_WORD;
            locked_r     <= 1'b0;
            prev_disp_r  <= IDLE_WORD;
        end else begin
            state_r      <= state_s;
            fail_count_r <= fail_count_s;
            countdown_r  <= countdown_s;
            sec_timer_r  <= sec_timer_s;
            display_r    <= display_s;
            locked_r     <= (state_r == ST_LOCKED);
            prev_disp_r  <= fsm_display;
        end
    end

endmodule

// File: tb/tb_keypad_lockout_ctrl.sv
module tb_keypad_lockout_ctrl;

    localparam int MF  = 3;
    localparam int LS  = 12;
    localparam int CPS = 10;
    localparam logic [15:0] FAILW = 16'hDA1E;
    localparam logic [15:0] PASSW = 16'hBACC;
    localparam logic [15:0] IDLEW = 16'hFFFF;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  key_value = 4'h0;
    logic        key_valid = 1'b0;
    logic [15:0] fsm_display = 16'hFFFF;
    logic [3:0]  fsm_key_value;
    logic        fsm_key_valid;
    logic [15:0] display_data;
    logic        locked;
    logic [3:0]  fail_count;

    keypad_lockout_ctrl #(.MAX_FAILS(MF), .LOCK_SEC(LS), .CYCLES_PER_SEC(CPS)) dut (
        .clk(clk), .reset(reset), .key_value(key_value), .key_valid(key_valid),
        .fsm_display(fsm_display), .fsm_key_value(fsm_key_value),
        .fsm_key_valid(fsm_key_valid), .display_data(display_data),
        .locked(locked), .fail_count(fail_count)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model state.
    // m_left is the number of locked cycles still remaining; 0 means armed.
    int          m_left  = 0;
    int          m_fails = 0;
    logic [15:0] m_prev  = 16'hFFFF;
    logic [15:0] m_dd    = 16'hFFFF;
    logic        m_lk    = 1'b0;

    typedef struct {
        logic        kv;
        logic [3:0]  kval;
        logic [15:0] disp;
        logic        exp_fkv;
        logic [15:0] exp_dd;
        logic [3:0]  exp_fc;
        logic        exp_lk;
    } vec_t;
    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Seconds remaining are rounded up, then shown as "L-" followed by two decimal digits.
    function automatic logic [15:0] lock_word(input int left);
        int s;
        s = (left + CPS - 1) / CPS;
        return {4'hE, 4'hF, 4'(s / 10), 4'(s % 10)};
    endfunction

    task automatic model_edge(input logic [15:0] d);
        logic armed;
        armed = (m_left == 0);
        m_dd  = armed ? d : lock_word(m_left);
        m_lk  = !armed;
        if (armed) begin
            if (d == PASSW && m_prev != PASSW) begin
                m_fails = 0;
            end else if (d == FAILW && m_prev != FAILW) begin
                if (m_fails == MF - 1) begin
                    m_fails = 0;
                    m_left  = LS * CPS;
                end else begin
                    m_fails++;
                end
            end
        end else begin
            m_left--;
        end
        m_prev = d;
    endtask

    task automatic cycle(input logic kv, input logic [3:0] kval, input logic [15:0] d,
                         output logic fkv, output logic [3:0] fval);
        @(negedge clk);
        key_valid = kv;
        key_value = kval;
        fsm_display = d;
        #1;
        fkv  = fsm_key_valid;
        fval = fsm_key_value;
        chk("model_fwd_valid", {31'd0, fkv}, {31'd0, kv && (m_left == 0)});
        chk("model_fwd_value", {28'd0, fval}, {28'd0, kval});
        model_edge(d);
        @(posedge clk);
        #1;
        chk("model_display", {16'd0, display_data}, {16'd0, m_dd});
        chk("model_locked", {31'd0, locked}, {31'd0, m_lk});
        chk("model_fail_count", {28'd0, fail_count}, m_fails);
    endtask

    task automatic step(input logic [15:0] d);
        logic a;
        logic [3:0] b;
        cycle(1'b0, 4'h0, d, a, b);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        key_valid = 1'b0;
        fsm_display = IDLEW;
        #1;
        chk("reset_display", {16'd0, display_data}, 32'h0000FFFF);
        chk("reset_locked", {31'd0, locked}, 32'd0);
        chk("reset_fail_count", {28'd0, fail_count}, 32'd0);
        m_left = 0; m_fails = 0; m_prev = IDLEW; m_dd = IDLEW; m_lk = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        logic       fkv;
        logic [3:0] fval;
        int         t_unlock;
        logic [15:0] dd_unlock;

        vecs[0] = '{1'b1, 4'h5, 16'hFFFF, 1'b1, 16'hFFFF, 4'd0, 1'b0};
        vecs[1] = '{1'b0, 4'h0, 16'hFFF5, 1'b0, 16'hFFF5, 4'd0, 1'b0};
        vecs[2] = '{1'b0, 4'h0, 16'hDA1E, 1'b0, 16'hDA1E, 4'd1, 1'b0};
        vecs[3] = '{1'b0, 4'h0, 16'hDA1E, 1'b0, 16'hDA1E, 4'd1, 1'b0};
        vecs[4] = '{1'b0, 4'h0, 16'hFFFF, 1'b0, 16'hFFFF, 4'd1, 1'b0};
        vecs[5] = '{1'b0, 4'h0, 16'hBACC, 1'b0, 16'hBACC, 4'd0, 1'b0};
        vecs[6] = '{1'b0, 4'h0, 16'hFFFF, 1'b0, 16'hFFFF, 4'd0, 1'b0};
        vecs[7] = '{1'b1, 4'h9, 16'hDA1E, 1'b1, 16'hDA1E, 4'd1, 1'b0};
        vecs[8] = '{1'b0, 4'h0, 16'hFFFF, 1'b0, 16'hFFFF, 4'd1, 1'b0};

        do_reset();

        // Table vectors: pass-through, one-cycle display latency, fail/pass counting.
        for (int i = 0; i < 9; i++) begin
            cycle(vecs[i].kv, vecs[i].kval, vecs[i].disp, fkv, fval);
            chk($sformatf("vec%0d_fkv", i), {31'd0, fkv}, {31'd0, vecs[i].exp_fkv});
            if (vecs[i].kv) chk($sformatf("vec%0d_fval", i), {28'd0, fval}, {28'd0, vecs[i].kval});
            chk($sformatf("vec%0d_dd", i), {16'd0, display_data}, {16'd0, vecs[i].exp_dd});
            chk($sformatf("vec%0d_fc", i), {28'd0, fail_count}, {28'd0, vecs[i].exp_fc});
            chk($sformatf("vec%0d_lk", i), {31'd0, locked}, {31'd0, vecs[i].exp_lk});
        end

        // A FAIL word held for 20 cycles counts once.
        do_reset();
        for (int i = 0; i < 20; i++) step(FAILW);
        step(IDLEW);
        chk("held_fail_count", {28'd0, fail_count}, 32'd1);

        // Lockout: three FAIL pulses, BCD countdown, dropped key, exact duration.
        do_reset();
        step(FAILW); step(IDLEW); step(FAILW); step(IDLEW);
        cycle(1'b1, 4'h7, FAILW, fkv, fval);
        chk("entry_key_forwarded", {31'd0, fkv}, 32'd1);
        chk("entry_fc_cleared", {28'd0, fail_count}, 32'd0);
        step(IDLEW);
        chk("lock_asserted", {31'd0, locked}, 32'd1);
        chk("lock_disp_12", {16'd0, display_data}, 32'h0000EF12);
        t_unlock = -1;
        dd_unlock = 16'h0000;
        for (int t = 1; t < 200; t++) begin
            cycle(t == 5, 4'h3, IDLEW, fkv, fval);
            if (t == 5)  chk("locked_key_dropped", {31'd0, fkv}, 32'd0);
            if (t == 10) chk("lock_disp_11", {16'd0, display_data}, 32'h0000EF11);
            if (t == 20) chk("lock_disp_10", {16'd0, display_data}, 32'h0000EF10);
            if (t == 30) chk("lock_disp_09", {16'd0, display_data}, 32'h0000EF09);
            if (!locked) begin
                t_unlock = t;
                dd_unlock = display_data;
                break;
            end
        end
        chk("lock_duration", t_unlock, 32'd120);
        chk("unlock_display", {16'd0, dd_unlock}, 32'h0000FFFF);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 4'h0, IDLEW, fkv, fval);
            chk("no_replay", {31'd0, fkv}, 32'd0);
        end

        // Reset in the middle of a lock.
        do_reset();
        step(FAILW); step(IDLEW); step(FAILW); step(IDLEW); step(FAILW);
        for (int i = 0; i < 50; i++) step(IDLEW);
        chk("midlock_locked", {31'd0, locked}, 32'd1);
        do_reset();
        step(FAILW);
        chk("post_reset_fail", {28'd0, fail_count}, 32'd1);
        step(IDLEW);

        // Randomized traffic against the reference model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            int r;
            logic [15:0] d;
            r = $urandom_range(0, 9);
            if (r < 3)       d = FAILW;
            else if (r == 3) d = PASSW;
            else if (r < 7)  d = IDLEW;
            else             d = 16'($urandom);
            if ($urandom_range(0, 599) == 0) do_reset();
            cycle($urandom_range(0, 3) == 0, 4'($urandom), d, fkv, fval);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
